// File: rtl/buz_pkg.sv
// Shared definitions for the multi-channel buzzer/relay blinker:
// channel state encoding, one-hot helpers and counter sizing.
package buz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // True when exactly one bit of the (zero-extended) field is set.
  function automatic logic is_onehot(input logic [31:0] f);
    return (f != 32'd0) && ((f & (f - 32'd1)) == 32'd0);
  endfunction

  // Index of the set bit of a one-hot field (0 when the field is empty).
  function automatic logic [4:0] onehot_index(input logic [31:0] f);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (f[i]) begin
        idx = 5'(i);
      end
    end
    return idx;
  endfunction

  // Bits needed for a counter that runs 0 .. v-1 (never less than one bit).
  function automatic int unsigned cnt_width(input longint unsigned v);
    if (v <= 64'd2) begin
      return 32'd1;
    end else begin
      return $clog2(v);
    end
  endfunction

endpackage

// File: rtl/buz_channel.sv
// One blinker channel: decodes its synchronised DIP field, runs the
// half-period counter, the burst pulse counter and the gap counter, and
// holds the IDLE/RUN/GAP state machine. Any change of mode or burst
// select restarts the pattern from a clean RUN entry.
module buz_channel
  import buz_pkg::*;
#(
  parameter int unsigned MODE_W         = 3,
  parameter int unsigned BASE_HALF_CYC  = 50000000,
  parameter int unsigned BURST_PULSES   = 3,
  parameter int unsigned BURST_GAP_HALF = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] mode,
  input  logic              burst,
  output logic              phase,
  output logic              phase_nxt,
  output logic              active
);

  localparam int unsigned CNT_W   = cnt_width(64'(BASE_HALF_CYC));
  localparam int unsigned GAP_W   = cnt_width(64'(BURST_GAP_HALF) * 64'(BASE_HALF_CYC));
  localparam int unsigned PULSE_W = cnt_width(64'(BURST_PULSES) + 64'd1);
  localparam logic [PULSE_W-1:0] PULSE_LAST = PULSE_W'(BURST_PULSES - 1);

  state_t              state_r, state_nxt_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;
  logic [GAP_W-1:0]    gcnt_r, gcnt_nxt_s;
  logic [PULSE_W-1:0]  pulse_r, pulse_nxt_s;
  logic                phase_r, phase_nxt_s;
  logic [MODE_W-1:0]   mode_r, mode_nxt_s;
  logic                burst_r, burst_nxt_s;
  logic                active_r;

  logic                valid_s;
  logic [4:0]          idx_s;
  logic [31:0]         half_full_s;
  logic [CNT_W-1:0]    half_m1_s;
  logic [GAP_W-1:0]    gap_m1_s;

  // Rate decode: the single set bit k selects BASE_HALF_CYC >> k.
  assign valid_s     = is_onehot(32'(mode));
  assign idx_s       = onehot_index(32'(mode));
  assign half_full_s = 32'(BASE_HALF_CYC) >> idx_s;
  assign half_m1_s   = CNT_W'(half_full_s - 32'd1);
  assign gap_m1_s    = GAP_W'(64'(BURST_GAP_HALF) * 64'(half_full_s) - 64'd1);

  // Next-state logic for the channel FSM and its counters.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    gcnt_nxt_s  = gcnt_r;
    pulse_nxt_s = pulse_r;
    phase_nxt_s = phase_r;
    mode_nxt_s  = mode_r;
    burst_nxt_s = burst_r;
    if (!valid_s) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = {CNT_W{1'b0}};
      gcnt_nxt_s  = {GAP_W{1'b0}};
      pulse_nxt_s = {PULSE_W{1'b0}};
      phase_nxt_s = 1'b0;
      mode_nxt_s  = {MODE_W{1'b0}};
      burst_nxt_s = 1'b0;
    end else if ((state_r == ST_IDLE) || (mode != mode_r) || (burst != burst_r)) begin
      // Fresh RUN entry: nothing from the previous pattern survives.
      state_nxt_s = ST_RUN;
      cnt_nxt_s   = {CNT_W{1'b0}};
      gcnt_nxt_s  = {GAP_W{1'b0}};
      pulse_nxt_s = {PULSE_W{1'b0}};
      phase_nxt_s = 1'b0;
      mode_nxt_s  = mode;
      burst_nxt_s = burst;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (cnt_r == half_m1_s) begin
            cnt_nxt_s   = {CNT_W{1'b0}};
            phase_nxt_s = ~phase_r;
            if (phase_r && burst_r) begin
              if (pulse_r == PULSE_LAST) begin
                state_nxt_s = ST_GAP;
                phase_nxt_s = 1'b0;
                pulse_nxt_s = {PULSE_W{1'b0}};
                gcnt_nxt_s  = {GAP_W{1'b0}};
              end else begin
                pulse_nxt_s = pulse_r + PULSE_W'(1);
              end
            end else begin
              pulse_nxt_s = pulse_r;
            end
          end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1);
          end
        end
        ST_GAP: begin
          phase_nxt_s = 1'b0;
          if (gcnt_r == gap_m1_s) begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = {CNT_W{1'b0}};
            gcnt_nxt_s  = {GAP_W{1'b0}};
            pulse_nxt_s = {PULSE_W{1'b0}};
          end else begin
            gcnt_nxt_s = gcnt_r + GAP_W'(1);
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = {CNT_W{1'b0}};
          gcnt_nxt_s  = {GAP_W{1'b0}};
          pulse_nxt_s = {PULSE_W{1'b0}};
          phase_nxt_s = 1'b0;
          mode_nxt_s  = {MODE_W{1'b0}};
          burst_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // Channel state, counters and registered phase/active outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      gcnt_r   <= {GAP_W{1'b0}};
      pulse_r  <= {PULSE_W{1'b0}};
      phase_r  <= 1'b0;
      mode_r   <= {MODE_W{1'b0}};
      burst_r  <= 1'b0;
      active_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      gcnt_r   <= gcnt_nxt_s;
      pulse_r  <= pulse_nxt_s;
      phase_r  <= phase_nxt_s;
      mode_r   <= mode_nxt_s;
      burst_r  <= burst_nxt_s;
      active_r <= (state_nxt_s != ST_IDLE);
    end
  end

  assign phase     = phase_r;
  assign phase_nxt = phase_nxt_s;
  assign active    = active_r;

endmodule

// File: rtl/buz_multi.sv
// Multi-channel buzzer/relay blinker top: synchronises the DIP switches,
// burst selects and MUTE button, runs N_CH independent channels and
// produces registered BUZZ/RELAY/ACTIVE pins. MUTE gates only the buzzers.
module buz_multi
  import buz_pkg::*;
#(
  parameter int unsigned N_CH           = 2,
  parameter int unsigned MODE_W         = 3,
  parameter int unsigned BASE_HALF_CYC  = 50000000,
  parameter int unsigned BURST_PULSES   = 3,
  parameter int unsigned BURST_GAP_HALF = 4
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic [N_CH*MODE_W-1:0] DIP_SW,
  input  logic [N_CH-1:0]        BURST,
  input  logic                   MUTE,
  output logic [N_CH-1:0]        BUZZ,
  output logic [N_CH-1:0]        RELAY,
  output logic [N_CH-1:0]        ACTIVE
);

  logic [N_CH*MODE_W-1:0] dip_s1_r, dip_s2_r;
  logic [N_CH-1:0]        burst_s1_r, burst_s2_r;
  logic                   mute_s1_r, mute_s2_r;
  logic [N_CH-1:0]        relay_s, phase_nxt_s, active_s;
  logic [N_CH-1:0]        buzz_r;

  // Two-flop synchronisers for the asynchronous switch and button inputs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      dip_s1_r   <= {(N_CH*MODE_W){1'b0}};
      dip_s2_r   <= {(N_CH*MODE_W){1'b0}};
      burst_s1_r <= {N_CH{1'b0}};
      burst_s2_r <= {N_CH{1'b0}};
      mute_s1_r  <= 1'b0;
      mute_s2_r  <= 1'b0;
    end else begin
      dip_s1_r   <= DIP_SW;
      dip_s2_r   <= dip_s1_r;
      burst_s1_r <= BURST;
      burst_s2_r <= burst_s1_r;
      mute_s1_r  <= MUTE;
      mute_s2_r  <= mute_s1_r;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    buz_channel #(
      .MODE_W         (MODE_W),
      .BASE_HALF_CYC  (BASE_HALF_CYC),
      .BURST_PULSES   (BURST_PULSES),
      .BURST_GAP_HALF (BURST_GAP_HALF)
    ) u_ch (
      .clk       (CLK),
      .rst_n     (RESET_N),
      .mode      (dip_s2_r[c*MODE_W +: MODE_W]),
      .burst     (burst_s2_r[c]),
      .phase     (relay_s[c]),
      .phase_nxt (phase_nxt_s[c]),
      .active    (active_s[c])
    );
  end

  // Buzzer register: follows the channel phase in lockstep with RELAY,
  // forced low while the synchronised MUTE is asserted.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      buzz_r <= {N_CH{1'b0}};
    end else begin
      buzz_r <= phase_nxt_s & ~{N_CH{mute_s2_r}};
    end
  end

  assign BUZZ   = buzz_r;
  assign RELAY  = relay_s;
  assign ACTIVE = active_s;

endmodule

// File: tb/tb_buz_multi.sv
// Self-checking bench for buz_multi with a small base rate. The reference
// model tracks, per channel, when the current pattern was entered and
// derives the expected output from the elapsed time in closed form.
module tb_buz_multi;

  localparam int N_CH   = 2;
  localparam int MODE_W = 3;
  localparam int BASE   = 16;
  localparam int PULSES = 3;
  localparam int GAPH   = 4;

  logic                   CLK;
  logic                   RESET_N;
  logic [N_CH*MODE_W-1:0] DIP_SW;
  logic [N_CH-1:0]        BURST;
  logic                   MUTE;
  logic [N_CH-1:0]        BUZZ;
  logic [N_CH-1:0]        RELAY;
  logic [N_CH-1:0]        ACTIVE;

  int n_cmp  = 0;
  int n_fail = 0;

  buz_multi #(
    .N_CH           (N_CH),
    .MODE_W         (MODE_W),
    .BASE_HALF_CYC  (BASE),
    .BURST_PULSES   (PULSES),
    .BURST_GAP_HALF (GAPH)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .DIP_SW  (DIP_SW),
    .BURST   (BURST),
    .MUTE    (MUTE),
    .BUZZ    (BUZZ),
    .RELAY   (RELAY),
    .ACTIVE  (ACTIVE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  logic [N_CH*MODE_W-1:0] h1_dip, h2_dip;
  logic [N_CH-1:0]        h1_burst, h2_burst;
  logic                   h1_mute, h2_mute;
  bit                     m_on    [N_CH];
  int unsigned            m_entry [N_CH];
  logic [MODE_W-1:0]      m_mode  [N_CH];
  bit                     m_bst   [N_CH];
  int unsigned            edge_n = 0;
  logic [N_CH-1:0]        exp_relay, exp_buzz, exp_active;

  function automatic int half_of(input logic [MODE_W-1:0] f);
    for (int k = 0; k < MODE_W; k++) begin
      if (f == (MODE_W'(1) << k)) return BASE >> k;
    end
    return 1;
  endfunction

  // High iff inside a pulse: continuous = odd half-periods; burst = odd
  // half-periods within the first 2*PULSES halves of each repeat.
  function automatic bit relay_at(input int unsigned el, input int half, input bit bst);
    int unsigned len, e;
    if (!bst) return ((el / half) % 2) == 1;
    len = (2 * PULSES + GAPH) * half;
    e   = el % len;
    return (e < 2 * PULSES * half) && (((e / half) % 2) == 1);
  endfunction

  function automatic bit in_gap(input int c);
    int half;
    int unsigned e;
    if (!m_on[c] || !m_bst[c]) return 1'b0;
    half = half_of(m_mode[c]);
    e    = (edge_n - m_entry[c]) % ((2 * PULSES + GAPH) * half);
    return e >= 2 * PULSES * half;
  endfunction

  task automatic model_reset();
    h1_dip = '0; h2_dip = '0; h1_burst = '0; h2_burst = '0;
    h1_mute = 1'b0; h2_mute = 1'b0;
    for (int c = 0; c < N_CH; c++) m_on[c] = 1'b0;
    exp_relay = '0; exp_buzz = '0; exp_active = '0;
  endtask

  task automatic model_edge();
    logic [N_CH*MODE_W-1:0] e_dip;
    logic [N_CH-1:0]        e_bst;
    logic                   e_mute;
    logic [MODE_W-1:0]      f;
    edge_n++;
    e_dip = h2_dip; e_bst = h2_burst; e_mute = h2_mute;
    h2_dip = h1_dip; h2_burst = h1_burst; h2_mute = h1_mute;
    h1_dip = DIP_SW; h1_burst = BURST; h1_mute = MUTE;
    for (int c = 0; c < N_CH; c++) begin
      f = e_dip[c*MODE_W +: MODE_W];
      if ($countones(f) != 1) begin
        m_on[c] = 1'b0;
      end else if (!m_on[c] || f != m_mode[c] || e_bst[c] != m_bst[c]) begin
        m_on[c] = 1'b1; m_entry[c] = edge_n; m_mode[c] = f; m_bst[c] = e_bst[c];
      end
      exp_active[c] = m_on[c];
      exp_relay[c]  = m_on[c] ? relay_at(edge_n - m_entry[c], half_of(m_mode[c]), m_bst[c]) : 1'b0;
    end
    exp_buzz = exp_relay & ~{N_CH{e_mute}};
  endtask

  // ---------------- checking helpers ----------------
  task automatic chk(input string tag, input logic [N_CH-1:0] obs, input logic [N_CH-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    if (!RESET_N) model_reset();
    else model_edge();
    @(negedge CLK);
    chk("relay", RELAY, exp_relay);
    chk("buzz", BUZZ, exp_buzz);
    chk("active", ACTIVE, exp_active);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_field(input int c, input logic [MODE_W-1:0] f);
    DIP_SW[c*MODE_W +: MODE_W] = f;
  endtask

  function automatic logic [MODE_W-1:0] rand_field();
    logic [MODE_W-1:0] one;
    one = MODE_W'(1);
    if ($urandom_range(0, 9) < 7) return one << $urandom_range(0, MODE_W - 1);
    return MODE_W'($urandom);
  endfunction

  // ---------------- directed / randomised sequence ----------------
  initial begin
    bit found;
    bit saw_high;
    bit buzz_seen;

    // Reset held with random inputs: everything must stay cleared.
    RESET_N = 1'b0;
    DIP_SW  = (N_CH*MODE_W)'($urandom);
    BURST   = N_CH'($urandom);
    MUTE    = 1'($urandom);
    model_reset();
    run(5);
    DIP_SW = '0; BURST = '0; MUTE = 1'b0;
    run(1);
    RESET_N = 1'b1;
    run(10);
    chk("idle_active", ACTIVE, 2'b00);

    // Continuous rates: ch0 slowest, ch1 fastest.
    set_field(0, 3'b001);
    set_field(1, 3'b100);
    run(90);

    // Burst on ch0 at HALF=8, ch1 keeps a random valid rate.
    set_field(0, 3'b010);
    set_field(1, rand_field());
    BURST = 2'b01;
    run(200);

    // Mode change while RELAY[0] is high.
    set_field(0, 3'b001);
    BURST = 2'b00;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (RELAY[0]) found = 1'b1;
    end
    chk1("wait_rise", found, 1'b1);
    set_field(0, 3'b010);
    run(4);
    chk1("mode_chg_drop", RELAY[0], 1'b0);
    run(40);

    // Invalid multi-bit field drops ch0 to IDLE.
    set_field(0, 3'b011);
    run(6);
    chk1("invalid_active", ACTIVE[0], 1'b0);
    chk1("invalid_relay", RELAY[0], 1'b0);

    // MUTE with a valid burst pattern: relay keeps going, buzzer silent.
    set_field(0, 3'b100);
    BURST = 2'b01;
    MUTE  = 1'b1;
    run(3);
    saw_high = 1'b0;
    buzz_seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (RELAY[0]) saw_high = 1'b1;
      if (BUZZ != '0) buzz_seen = 1'b1;
    end
    chk1("mute_relay_runs", saw_high, 1'b1);
    chk1("mute_buzz_quiet", buzz_seen, 1'b0);
    MUTE = 1'b0;
    run(20);

    // Randomised segments.
    for (int s = 0; s < 15; s++) begin
      for (int c = 0; c < N_CH; c++) set_field(c, rand_field());
      BURST = N_CH'($urandom);
      MUTE  = ($urandom_range(0, 3) == 0);
      run($urandom_range(10, 120));
    end

    // Asynchronous reset in the middle of a burst gap.
    set_field(0, 3'b010);
    BURST = 2'b01;
    MUTE  = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 250 && !found; i++) begin
      tick();
      if (in_gap(0) && (edge_n - m_entry[0]) > 60) found = 1'b1;
    end
    chk1("wait_gap", found, 1'b1);
    #1;
    RESET_N = 1'b0;
    #1;
    chk("rst_relay", RELAY, 2'b00);
    chk("rst_buzz", BUZZ, 2'b00);
    chk("rst_active", ACTIVE, 2'b00);
    model_reset();
    #1;
    RESET_N = 1'b1;
    run(60);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/buz_multi.md
Name: buz_multi

Overview:
- Parametrised, multi-channel successor to the single buzzer/relay blinker.
- N_CH independent channels. Each one-hot DIP field selects a toggle rate derived from BASE_HALF_CYC by right shift.
- Each channel runs either a continuous square wave or a burst pattern (N pulses, then a silent gap).
- Sits between the board DIP switches/buttons and the buzzer and relay pins. A global MUTE silences buzzers while relays keep running.

Parameters:
- N_CH, 2, number of independent channels
- MODE_W, 3, DIP bits per channel; bit k alone selects half-period BASE_HALF_CYC >> k
- BASE_HALF_CYC, 50000000, half-period in CLK cycles for bit 0 (1 s at 50 MHz); must satisfy BASE_HALF_CYC >> (MODE_W-1) >= 2
- BURST_PULSES, 3, full high+low pulses per burst
- BURST_GAP_HALF, 4, gap length in half-periods of the active rate

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous, active-low reset
- DIP_SW  in  N_CH*MODE_W  channel c field = DIP_SW[c*MODE_W +: MODE_W]; asynchronous
- BURST  in  N_CH  per-channel burst-mode select; asynchronous
- MUTE  in  1  forces all BUZZ low; asynchronous
- BUZZ  out  N_CH  buzzer drive, registered
- RELAY  out  N_CH  relay drive, registered
- ACTIVE  out  N_CH  channel has a valid mode (state != IDLE)

Behaviour:
Reset and synchronisation
- Reset is asynchronous, active-low, on CLK rising edge domain.
- While RESET_N = 0: all outputs 0; all counters, sync flops and states cleared (IDLE).
- All async inputs (DIP_SW, BURST, MUTE) pass through a 2-flop synchroniser. Latency from input change to effect is 3 CLK edges.

Mode decode
- Valid mode = exactly one bit set in the synced field.
- Zero or multi-bit field -> IDLE. In IDLE, outputs are 0 and the counter is 0.
- HALF = BASE_HALF_CYC >> k, where k is the index of the set bit.

Per-channel state machine (IDLE, RUN, GAP)
- IDLE -> RUN when mode becomes valid. Entry sets cnt=0, phase=0, pulse_cnt=0.
- Mode change or BURST change while not IDLE: restart from RUN entry with output 0 on the next edge. No stale count carries over.
- RUN:
  - cnt increments each cycle. When cnt == HALF-1: cnt <= 0 and phase toggles.
  - First rising edge of phase occurs exactly HALF cycles after entry; period is 2*HALF exactly.
- Burst mode (synced BURST=1):
  - pulse_cnt increments on each phase 1->0 toggle.
  - On the toggle that completes pulse BURST_PULSES: go to GAP with phase 0.
- GAP:
  - phase held 0; counts BURST_GAP_HALF*HALF cycles.
  - Then -> RUN with cnt=0 and pulse_cnt=0. The next rising edge follows HALF cycles later.
- Continuous mode: RUN never exits except to IDLE or on restart.

Outputs
- RELAY[c] = phase.
- BUZZ[c] = phase & ~MUTE_sync.
- ACTIVE[c] = (state != IDLE).
- All outputs are registered, with no combinational path from inputs.

Widths
- cnt width = $clog2(BASE_HALF_CYC). Gap counter width = $clog2(BURST_GAP_HALF*BASE_HALF_CYC).
- pulse_cnt width = $clog2(BURST_PULSES+1).
- No wrap-around is possible; counters never exceed their terminal values.

Boundary conditions
- Invalid mode mid-pulse: output drops to 0 on the next edge.
- MUTE mid-burst: only BUZZ is affected; pattern timing is unchanged.
- Reset asserted mid-operation: immediate clear; resumes from IDLE after release.

Decomposition:
- Shared package buz_pkg holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, GAP=2'd2
  - one-hot validity and index functions
  - counter-width helper
- Sub-module buz_channel (one channel: decode, counters, FSM) is instantiated N_CH times by generate in buz_multi.
- buz_multi owns the synchronisers and the MUTE gating.

Test Plan:
- Reset: RESET_N=0 with random inputs -> all outputs 0. Release with DIP=000 -> outputs stay 0, ACTIVE=0.
- Continuous rate (BASE_HALF_CYC=16, N_CH=2): ch0 DIP=001 -> RELAY[0] high 16, low 16 repeating, first rise 16 cycles after mode effect; ch1 DIP=100 -> half-period 4, independent.
- Burst (DIP=010, BURST=1, HALF=8): 3 pulses of 8 high/8 low, then 32 cycles low, repeating; BUZZ matches RELAY.
- Mode change mid-pulse: 001 -> 010 while RELAY=1 -> RELAY=0 by 4 edges after the change, then 8-cycle half-periods.
- Invalid mode and MUTE: DIP=011 -> IDLE, outputs 0, ACTIVE=0. Valid mode with MUTE=1 -> BUZZ=0 while RELAY keeps toggling.
- Async reset mid-GAP: RESET_N pulsed low between edges -> immediate clear. After release, first rise HALF cycles after re-entry.
